exe_muldiv_ctrl: RTL and testbench
==================================

// Module: exe_muldiv_ctrl
// PURPOSE
//  Sequencing controller plus iterative datapath for RV64M multiply/divide in the execute stage.
//  Accepts one M-extension op from exe via valid/ready, runs a radix-2 shift-add or shift-subtract loop, applies sign fix-up, and returns the result.
//  Holds stall_o to freeze the pipeline for the whole operation; the ALU keeps serving non-M ops.
// PARAMETERS
//  XLEN   64   operand/result width; equals width of `REG_BUS
//  CNT_W  7    iteration counter width; must satisfy 2**CNT_W > XLEN
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst        in   1     synchronous reset, active-high
//  flush_i    in   1     kill in-flight op (branch redirect/trap)
//  valid_i    in   1     request valid
//  ready_o    out  1     controller can accept a request
//  funct3_i   in   3     M op: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  word_i     in   1     *W variant (32-bit op, sign-extended result)
//  op1_i      in   XLEN  rs1 value
//  op2_i      in   XLEN  rs2 value
//  valid_o    out  1     result valid, held until ready_i
//  ready_i    in   1     exe/wb consumes result
//  result_o   out  XLEN  result
//  stall_o    out  1     pipeline stall request
// BEHAVIOUR
//  - Reset: state IDLE; ready_o=1, valid_o=0, stall_o=0, result_o=0, counter=0.
//  - FSM IDLE->CALC->FIX->DONE->IDLE; fast path IDLE->DONE.
//  - IDLE: accept when valid_i & ready_o & !flush_i; latch funct3, word, abs operands, sign flags.
//    ready_o=1 only in IDLE.
//  - W ops: operands are the low 32 bits, sign- or zero-extended per op. N=32 iterations; else N=XLEN.
//  - CALC: one iteration per cycle; counter counts down from N-1, leaves for FIX at 0.
//    MUL*: 2N-bit product register. DIV/REM: restoring division; remainder N+1 bits.
//  - FIX: negate quotient if s1^s2 (signed div); negate remainder if s1 (signed rem).
//    Negate the 2N product if the signs differ (MULH signed, MULHSU uses op1 sign only).
//    Select low or high half; W ops sign-extend bit 31.
//  - DONE: valid_o=1, result_o stable; on ready_i go IDLE the next cycle.
//  - Latency: accept in cycle 0; valid_o in cycle N+2 (66 for 64-bit ops, 34 for W ops).
//  - Fast path (decided at accept, DONE in cycle 1):
//    div by zero: quotient all-ones (W: sign-extended 0xFFFFFFFF), remainder = dividend.
//    signed overflow (MIN / -1): quotient = MIN, remainder = 0 (W: sign-extended).
//  - stall_o = (valid_i & ready_o & !flush_i) | (state!=IDLE & !(state==DONE & ready_i)).
//    It drops in the cycle the result handshake completes.
//  - flush_i: in any state, next state is IDLE and valid_o=0 next cycle; no result is produced.
//    It beats a same-cycle accept (request dropped) and a same-cycle DONE handshake (result discarded).
//  - rst mid-op: same as flush, and all registers return to reset values.
//  - valid_i while busy: ignored; requester must hold it (ready_o=0).
//  - Operand regs are written only at accept; op1_i/op2_i changes mid-op have no effect.
// STRUCTURE
//  - defines.v: `MD_MUL..`MD_REMU funct3 codes, FSM state encodings `MD_IDLE/`MD_CALC/`MD_FIX/`MD_DONE, `REG_BUS.
//  - Top: FSM, counter, handshake, stall, fast-path detect.
//  - Sub-module muldiv_iter_unit: shift-add/shift-subtract step and sign fix-up.
//    Pure datapath with a load/step/fix control interface from the FSM.
// TESTING
//  - MUL 7*(-3): valid_o at cycle 66, result 0xFFFF_FFFF_FFFF_FFEB; stall_o high cycles 0..65 with ready_i=1.
//  - MULHU 0xFFFF_FFFF_FFFF_FFFF*2 -> 1. MULH -1*-1 -> 0. MULHSU -1*2 -> 0xFFFF_FFFF_FFFF_FFFF.
//  - DIV -7/2 -> -3; REM -7/2 -> -1. DIVUW 0xFFFF_FFFF/2 -> 0x7FFF_FFFF, valid at cycle 34.
//  - DIV x/0 -> all-ones and REM 5/0 -> 5, both at cycle 1.
//    DIV 0x8000_0000_0000_0000/-1 -> same value; REMW MIN/-1 -> 0.
//  - flush_i at cycle 20 of a DIV -> IDLE at 21, ready_o=1, no valid_o. New MUL 3*4 -> 12 at correct latency.
//  - ready_i low for 5 cycles in DONE: valid_o and result held, stall_o held. valid_i during CALC is not accepted.

Source files
------------

// File: rtl/exe_muldiv_ctrl_pkg.sv
// M-extension op codes, controller states and operand-signedness helpers shared by the
// multiply/divide controller and its iterative datapath.
package exe_muldiv_ctrl_pkg;

    localparam int MD_XLEN  = 64;
    localparam int MD_CNT_W = 7;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic op1_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

    function automatic logic op2_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

    // *W operands are sign-extended except for the unsigned divide/remainder forms.
    function automatic logic word_signed(input logic [2:0] f3);
        return !((f3 == MD_DIVU) || (f3 == MD_REMU));
    endfunction

endpackage

// File: rtl/exe_muldiv_ctrl_iter.sv
// Radix-2 shift-add / restoring shift-subtract datapath with sign fix-up; load latches
// magnitudes, each step does one iteration, result is the combinational fixed-up answer.
module exe_muldiv_ctrl_iter
    import exe_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic            word,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] result
);

    logic [XLEN:0]     acc;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   mcand;
    logic [2:0]        f3_q;
    logic              word_q;
    logic              s1_q;
    logic              s2_q;

    logic              s1;
    logic              s2;
    logic [XLEN-1:0]   abs1;
    logic [XLEN-1:0]   abs2;
    logic [XLEN-1:0]   mul_a;
    logic [XLEN-1:0]   mul_b;
    logic [XLEN-1:0]   dvd;
    logic [XLEN-1:0]   addend;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     shifted;
    logic [XLEN+1:0]   diff;

    assign s1    = op1_signed(funct3) & op1[XLEN-1];
    assign s2    = op2_signed(funct3) & op2[XLEN-1];
    assign abs1  = s1 ? -op1 : op1;
    assign abs2  = s2 ? -op2 : op2;
    assign mul_a = word ? {{(XLEN-32){1'b0}}, abs1[31:0]} : abs1;
    assign mul_b = word ? {{(XLEN-32){1'b0}}, abs2[31:0]} : abs2;
    // W dividends sit in the top half so every iteration consumes lo's MSB.
    assign dvd   = word ? {abs1[31:0], {(XLEN-32){1'b0}}} : abs1;

    assign addend  = lo[0] ? mcand : '0;
    assign sum     = acc + {1'b0, addend};
    assign shifted = {acc[XLEN-1:0], lo[XLEN-1]};
    assign diff    = {1'b0, shifted} - {2'b00, mcand};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            lo     <= '0;
            mcand  <= '0;
            f3_q   <= '0;
            word_q <= 1'b0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            f3_q   <= funct3;
            word_q <= word;
            s1_q   <= s1;
            s2_q   <= s2;
            mcand  <= funct3[2] ? abs2 : mul_a;
            lo     <= funct3[2] ? dvd  : mul_b;
        end else if (step) begin
            if (f3_q[2]) begin
                acc <= diff[XLEN+1] ? shifted : diff[XLEN:0];
                lo  <= {lo[XLEN-2:0], ~diff[XLEN+1]};
            end else begin
                acc <= {1'b0, sum[XLEN:1]};
                lo  <= {sum[0], lo[XLEN-1:1]};
            end
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   sel;

    always_comb begin
        prod     = {acc[XLEN-1:0], lo};
        prod_fix = (s1_q ^ s2_q) ? -prod : prod;
        quo      = (s1_q ^ s2_q) ? -lo : lo;
        rem      = s1_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        sel      = '0;
        case (f3_q)
            // After 32 shift-add steps the low product word has drifted into lo's top half.
            MD_MUL:                       sel = word_q ? {{(XLEN-32){1'b0}}, lo[XLEN-1:32]}
                                                       : prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: sel = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              sel = quo;
            default:                      sel = rem;
        endcase
        result = word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// RV64M multiply/divide sequencer: accepts one op, iterates N cycles (result at N+2, or
// cycle 1 for divide-by-zero/overflow), holds stall_o and valid_o until ready_i.
module exe_muldiv_ctrl
    import exe_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            stall_o
);

    md_state_e        state;
    md_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  res;
    logic [XLEN-1:0]  iter_res;

    logic [XLEN-1:0]  op1_ext;
    logic [XLEN-1:0]  op2_ext;
    logic [XLEN-1:0]  min_val;
    logic [XLEN-1:0]  fast_raw;
    logic [XLEN-1:0]  fast_res;
    logic             accept;
    logic             div_zero;
    logic             div_ovf;
    logic             fast;

    always_comb begin
        op1_ext = op1_i;
        op2_ext = op2_i;
        if (word_i) begin
            op1_ext = {{(XLEN-32){word_signed(funct3_i) & op1_i[31]}}, op1_i[31:0]};
            op2_ext = {{(XLEN-32){word_signed(funct3_i) & op2_i[31]}}, op2_i[31:0]};
        end
    end

    assign ready_o  = (state == MD_IDLE);
    assign accept   = valid_i & ready_o & ~flush_i;
    assign min_val  = word_i ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero = funct3_i[2] & (op2_ext == '0);
    assign div_ovf  = funct3_i[2] & ~funct3_i[0] & (op1_ext == min_val) & (&op2_ext);
    assign fast     = div_zero | div_ovf;

    always_comb begin
        fast_raw = '0;
        if (div_zero)
            fast_raw = funct3_i[1] ? op1_ext : '1;
        else
            fast_raw = funct3_i[1] ? '0 : op1_ext;
        fast_res = word_i ? {{(XLEN-32){fast_raw[31]}}, fast_raw[31:0]} : fast_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (accept) state_nxt = fast ? MD_DONE : MD_CALC;
            MD_CALC: if (cnt == '0) state_nxt = MD_FIX;
            MD_FIX:  state_nxt = MD_DONE;
            MD_DONE: if (ready_i) state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
        if (flush_i) state_nxt = MD_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            res <= '0;
        end else begin
            if (accept)
                cnt <= word_i ? CNT_W'(31) : CNT_W'(XLEN-1);
            else if (state == MD_CALC && cnt != '0)
                cnt <= cnt - 1'b1;

            if (accept && fast)
                res <= fast_res;
            else if (state == MD_FIX)
                res <= iter_res;
        end
    end

    exe_muldiv_ctrl_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (state == MD_CALC),
        .funct3 (funct3_i),
        .word   (word_i),
        .op1    (op1_ext),
        .op2    (op2_ext),
        .result (iter_res)
    );

    assign valid_o  = (state == MD_DONE);
    assign result_o = res;
    assign stall_o  = accept | ((state != MD_IDLE) & ~((state == MD_DONE) & ready_i));

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Self-checking bench for exe_muldiv_ctrl: directed table, corner sequences and random ops
// scored against an arithmetic reference model.
module tb_exe_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  funct3_i = '0;
    logic        word_i = 1'b0;
    logic [63:0] op1_i = '0;
    logic [63:0] op2_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [63:0] result_o;
    logic        stall_o;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    exe_muldiv_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .funct3_i (funct3_i),
        .word_i   (word_i),
        .op1_i    (op1_i),
        .op2_i    (op2_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .stall_o  (stall_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  ua, ub;
        int           sa, sb;
        longint       la, lb;
        ua = a[31:0]; ub = b[31:0]; sa = ua; sb = ub;
        la = a; lb = b;
        if (w) begin
            case (f3)
                3'd0: begin p = {96'b0, ua} * {96'b0, ub}; return sx32(p[31:0]); end
                3'd4: if (ub == 0) return ONES;
                      else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return sx32(ua);
                      else return sx32(32'(sa / sb));
                3'd5: return (ub == 0) ? ONES : sx32(ua / ub);
                3'd6: if (ub == 0) return sx32(ua);
                      else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return 64'd0;
                      else return sx32(32'(sa % sb));
                3'd7: return (ub == 0) ? sx32(ua) : sx32(ua % ub);
                default: return 64'd0;
            endcase
        end
        case (f3)
            3'd0: begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
            3'd3: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
            3'd4: if (b == 0) return ONES;
                  else if (a == MIN64 && b == ONES) return a;
                  else return 64'(la / lb);
            3'd5: return (b == 0) ? ONES : a / b;
            3'd6: if (b == 0) return a;
                  else if (a == MIN64 && b == ONES) return 64'd0;
                  else return 64'(la % lb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf;
        zero = w ? (b[31:0] == 0) : (b == 0);
        ovf  = !f3[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                            : (a == MIN64 && b == ONES));
        if (f3[2] && (zero || ovf)) return 1;
        return w ? 34 : 66;
    endfunction

    // Issue one op, track its cycle-accurate completion and handshake.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                          input int lat, input int hold, input bit poke);
        int k;
        bit stall_bad;
        @(posedge clk); #1;
        valid_i = 1'b1; funct3_i = f3; word_i = w; op1_i = a; op2_i = b;
        ready_i = (hold == 0);
        @(negedge clk);
        chk({tag, ":rdy0"}, 64'(ready_o), 64'd1);
        chk({tag, ":stall0"}, 64'(stall_o), 64'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        op1_i = {$urandom, $urandom};
        op2_i = {$urandom, $urandom};
        k = 0;
        stall_bad = 1'b0;
        do begin
            @(negedge clk);
            k++;
            if (poke && k == 10) begin
                valid_i = 1'b1; funct3_i = 3'd0; word_i = 1'b0; op1_i = 64'd5; op2_i = 64'd9;
                chk({tag, ":busy_rdy"}, 64'(ready_o), 64'd0);
            end
            if (poke && k == 12) valid_i = 1'b0;
            if (!valid_o && !stall_o) stall_bad = 1'b1;
        end while (!valid_o && k < 200);
        chk({tag, ":lat"}, 64'(k), 64'(lat));
        chk({tag, ":res"}, result_o, exp);
        chk({tag, ":stall_run"}, 64'(stall_bad), 64'd0);
        for (int h = 0; h < hold; h++) begin
            if (h > 0) @(negedge clk);
            chk({tag, ":hold_vld"}, 64'(valid_o), 64'd1);
            chk({tag, ":hold_res"}, result_o, exp);
            chk({tag, ":hold_stall"}, 64'(stall_o), 64'd1);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            ready_i = 1'b1;
            @(negedge clk);
            chk({tag, ":hs_vld"}, 64'(valid_o), 64'd1);
        end
        chk({tag, ":hs_stall"}, 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, ":idle_rdy"}, 64'(ready_o), 64'd1);
        chk({tag, ":idle_vld"}, 64'(valid_o), 64'd0);
    endtask

    function automatic logic [63:0] rnd_operand();
        int v;
        case ($urandom_range(0, 5))
            0: return {$urandom, $urandom};
            1: begin v = $urandom_range(0, 200); v -= 100; return 64'(longint'(v)); end
            2: return 64'd0;
            3: return ($urandom_range(0, 1) != 0) ? MIN64 : sx32(32'h8000_0000);
            4: return ONES;
            default: return {32'd0, $urandom};
        endcase
    endfunction

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[13];

    initial begin
        bit seen;
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a, b;

        tbl[0]  = '{"mul",      3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
        tbl[1]  = '{"mulhu",    3'd3, 1'b0, ONES, 64'd2, 64'd1, 66};
        tbl[2]  = '{"mulh",     3'd1, 1'b0, ONES, ONES, 64'd0, 66};
        tbl[3]  = '{"mulhsu",   3'd2, 1'b0, ONES, 64'd2, ONES, 66};
        tbl[4]  = '{"div",      3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
        tbl[5]  = '{"rem",      3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66};
        tbl[6]  = '{"divuw",    3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF, 34};
        tbl[7]  = '{"div0",     3'd4, 1'b0, 64'd12345, 64'd0, ONES, 1};
        tbl[8]  = '{"rem0",     3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
        tbl[9]  = '{"divovf",   3'd4, 1'b0, MIN64, ONES, MIN64, 1};
        tbl[10] = '{"remwovf",  3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1};
        tbl[11] = '{"mulw",     3'd0, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, ONES - 64'd1, 34};
        tbl[12] = '{"divu",     3'd5, 1'b0, 64'd1000, 64'd7, 64'd142, 66};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset:rdy", 64'(ready_o), 64'd1);
        chk("reset:vld", 64'(valid_o), 64'd0);
        chk("reset:stall", 64'(stall_o), 64'd0);
        chk("reset:res", result_o, 64'd0);

        foreach (tbl[i])
            run_op(tbl[i].name, tbl[i].f3, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 0, 1'b0);

        // Flush at cycle 20 of a DIV: back to IDLE at 21 with no result.
        @(posedge clk); #1;
        valid_i = 1'b1; funct3_i = 3'd4; word_i = 1'b0; op1_i = 64'd100; op2_i = 64'd7;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (19) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        chk("flush:vld20", 64'(valid_o), 64'd0);
        @(posedge clk); #1 flush_i = 1'b0;
        @(negedge clk);
        chk("flush:rdy21", 64'(ready_o), 64'd1);
        chk("flush:stall21", 64'(stall_o), 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        chk("flush:no_vld", 64'(seen), 64'd0);
        run_op("post_flush_mul", 3'd0, 1'b0, 64'd3, 64'd4, 64'd12, 66, 0, 1'b0);

        // Flush in the accept cycle drops the request.
        @(posedge clk); #1;
        valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd0; word_i = 1'b0; op1_i = 64'd2; op2_i = 64'd2;
        @(negedge clk);
        chk("flushacc:stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (valid_o || !ready_o) seen = 1'b1;
        end
        chk("flushacc:idle", 64'(seen), 64'd0);

        // Result held under ready_i backpressure, busy requests ignored.
        run_op("hold_div", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF00, 64'd3,
               model(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF00, 64'd3), 66, 5, 1'b1);

        // Reset mid-op returns everything to reset values.
        @(posedge clk); #1;
        valid_i = 1'b1; funct3_i = 3'd0; word_i = 1'b0; op1_i = 64'd9; op2_i = 64'd9;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid:rdy", 64'(ready_o), 64'd1);
        chk("rstmid:vld", 64'(valid_o), 64'd0);
        chk("rstmid:stall", 64'(stall_o), 64'd0);
        chk("rstmid:res", result_o, 64'd0);

        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom_range(0, 7));
            w  = (f3 == 3'd0 || f3[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
            a  = rnd_operand();
            b  = ($urandom_range(0, 7) == 0) ? 64'd0 : rnd_operand();
            run_op($sformatf("rnd%0d_f%0d_w%0d", n, f3, w), f3, w, a, b,
                   model(f3, w, a, b), exp_lat(f3, w, a, b), 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
